uart_tx_framed: RTL
===================

Name: uart_tx_framed

Overview:
- Parametrised UART transmitter for the debug peripheral; successor to the fixed 8N1 transmitter.
- Adds a write-side FIFO, a runtime baud divisor, a configurable data width, optional odd/even parity and 1 or 2 stop bits.
- Consecutive FIFO entries go out back-to-back with no idle gap.
- Sits between the debug peripheral's response logic and the board TX pin.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal 5..9, sent LSB first
FIFO_DEPTH, 4, entries in the TX FIFO, power of two, >= 2
CNT_WIDTH, 16, width of the baud divisor and bit-period counter

Ports:
i_Clock  in  1  system clock
i_Reset_N  in  1  asynchronous active-low reset
i_Clks_Per_Bit  in  CNT_WIDTH  clocks per bit; 0 treated as 1
i_Parity_Mode  in  2  00 none, 01 odd, 10 even, 11 none
i_Two_Stop  in  1  1 = two stop bits, 0 = one
i_Tx_DV  in  1  write strobe, one entry per cycle high
i_Tx_Data  in  DATA_WIDTH  data word to enqueue
o_Tx_Ready  out  1  FIFO not full
o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_Overflow  out  1  one-cycle pulse: i_Tx_DV while full, word dropped
o_Tx_Serial  out  1  serial line, idle high
o_Tx_Busy  out  1  high while in any non-IDLE state
o_Tx_Done  out  1  one-cycle pulse per completed frame

Behaviour:
- Reset (async assert, sync-safe deassert by system): o_Tx_Serial=1, o_Tx_Busy=0, o_Tx_Done=0, o_Overflow=0, o_Tx_Ready=1, o_Fifo_Count=0.
  - FIFO pointers cleared, state=IDLE.
  - Reset mid-frame aborts the frame; the line goes high immediately and queued words are lost.
- FIFO write:
  - A write is accepted when i_Tx_DV=1 and the FIFO is not full; occupancy rises at that edge.
  - Full plus i_Tx_DV: the word is dropped and o_Overflow pulses the next cycle.
  - A write while full is rejected even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves occupancy unchanged.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line high. If the FIFO is non-empty, pop the head into the shift register, latch i_Clks_Per_Bit, i_Parity_Mode and i_Two_Stop, and go to START.
  - Latency: o_Tx_Serial goes low on the edge after the write is accepted into an empty FIFO (1 cycle).
  - Latched config holds for the whole frame; config changes mid-frame have no effect on that frame.
  - START: drive 0 for N cycles (N = latched divisor, min 1), then go to DATA.
  - DATA: drive bit[idx], LSB first, N cycles each. After bit DATA_WIDTH-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: drive XOR of the data bits for even mode, its inverse for odd mode, for N cycles.
  - STOP: drive 1 for N cycles, or 2N with two stop bits.
  - On the last STOP cycle, o_Tx_Done is set for exactly one cycle.
  - At that same edge: if the FIFO is non-empty, pop and go straight to START (no idle cycle between frames); otherwise go to IDLE.
- Frame length is exactly (1 + DATA_WIDTH + P + S) x N cycles, where P ∈ {0,1} and S ∈ {1,2}.
- The bit counter counts 0..N-1; no other wrap is exposed. FIFO pointers wrap modulo FIFO_DEPTH.
- o_Tx_Busy is 0 only in IDLE.
- o_Tx_Ready = (count != FIFO_DEPTH), registered-consistent with o_Fifo_Count.

Test Plan:
- N=4, parity none, one stop, write 0x55: line low for 4 cycles starting 1 cycle after the write, then 1,0,1,0,1,0,1,0 at 4 cycles each, high for 4. o_Tx_Done pulses once at cycle 40 of the frame.
- N=3, even parity, write 0x03 -> parity bit 0. Odd parity, write 0x07 -> parity bit 0. Odd parity, write 0x03 -> parity bit 1. Frame = 33 cycles.
- i_Two_Stop=1, N=2, write 0xFF: stop high for 4 cycles. Frame = 22 cycles. A config change mid-frame does not alter the stop length.
- Write 6 words on consecutive cycles, FIFO_DEPTH=4: first 5 accepted (the first word pops into the shifter). The 6th produces an o_Overflow pulse, with o_Tx_Ready low before the write. Frames transmit back-to-back with no high gap between stop and start. o_Tx_Done pulses 5 times.
- Assert i_Reset_N=0 mid-DATA of the second queued frame: o_Tx_Serial=1 with no clock edge. After release: o_Fifo_Count=0, o_Tx_Busy=0, no further o_Tx_Done.
- i_Clks_Per_Bit=0, write 0xA5: each bit lasts 1 cycle and the frame is 10 cycles.

Source files
------------

// File: rtl/uart_tx_framed.sv
// uart_tx_framed: UART transmitter with a write-side FIFO and a runtime
// frame format.
//
// Each frame is a start bit (0), DATA_WIDTH data bits sent LSB first, an
// optional parity bit and one or two stop bits (1). Every bit lasts N clocks,
// where N is the baud divisor captured when the word leaves the FIFO (0 is
// treated as 1). Queued words go out back-to-back with no idle gap.
//
// Ports:
//   i_Clock         system clock
//   i_Reset_N       asynchronous active-low reset; aborts any frame in flight
//   i_Clks_Per_Bit  clocks per bit (0 treated as 1), captured per frame
//   i_Parity_Mode   00 none, 01 odd, 10 even, 11 none; captured per frame
//   i_Two_Stop      1 = two stop bits, 0 = one; captured per frame
//   i_Tx_DV         write strobe, one word per cycle high
//   i_Tx_Data       word to enqueue
//   o_Tx_Ready      FIFO not full
//   o_Fifo_Count    current FIFO occupancy
//   o_Overflow      one-cycle pulse after a write attempted while full
//   o_Tx_Serial     serial line, idle high
//   o_Tx_Busy       high whenever a frame is in progress
//   o_Tx_Done       high during the last clock of each frame's final stop bit

module uart_tx_framed #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_N,
    input  logic [CNT_WIDTH-1:0]          i_Clks_Per_Bit,
    input  logic [1:0]                    i_Parity_Mode,
    input  logic                          i_Two_Stop,
    input  logic                          i_Tx_DV,
    input  logic [DATA_WIDTH-1:0]         i_Tx_Data,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Overflow,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Busy,
    output logic                          o_Tx_Done
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int IDX_W  = $clog2(DATA_WIDTH);

    localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
    localparam logic [FCNT_W-1:0]    FCNT_ONE  = FCNT_W'(1);
    localparam logic [FCNT_W-1:0]    FIFO_FULL = FCNT_W'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]     count_q,  count_d;
    logic                  ovf_q,    ovf_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wr_en;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    // ------------------------------------------------------------------
    // Transmit engine state
    // ------------------------------------------------------------------
    state_t                state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [CNT_WIDTH-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [CNT_WIDTH-1:0]  clks_q,     clks_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_bit_q,  par_bit_d;
    logic                  two_stop_q, two_stop_d;
    logic                  stop_idx_q, stop_idx_d;

    logic                  bit_end;
    logic                  load;
    logic                  frame_done;

    assign fifo_full  = (count_q == FIFO_FULL);
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign bit_end    = (bit_cnt_q == clks_q - CNT_ONE);

    // A write is judged against the occupancy before any same-cycle pop,
    // so a full FIFO rejects the word even if the engine drains one.
    always_comb begin
        wr_en    = i_Tx_DV && !fifo_full;
        ovf_d    = i_Tx_DV && fifo_full;
        wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop   ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + FCNT_ONE;
            2'b01:   count_d = count_q - FCNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Next-state logic. Loading a new word can happen from IDLE or directly
    // from the final stop cycle, so the load side effects are gathered after
    // the case statement rather than duplicated in both branches.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        clks_d     = clks_q;
        idx_d      = idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop_idx_d = stop_idx_q;
        load       = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = ST_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        stop_idx_d = 1'b0;
                        state_d    = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    bit_cnt_d  = '0;
                    stop_idx_d = 1'b0;
                    state_d    = ST_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    // stop_idx_q counts stop bits already sent (0 or 1);
                    // it equals two_stop_q on the final one.
                    if (stop_idx_q == two_stop_q) begin
                        frame_done = 1'b1;
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            shift_d    = head;
            clks_d     = (i_Clks_Per_Bit == '0) ? CNT_ONE : i_Clks_Per_Bit;
            par_en_d   = (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
            // Even parity is the XOR of the data bits; odd is its inverse.
            par_bit_d  = (^head) ^ (i_Parity_Mode == 2'b01);
            two_stop_d = i_Two_Stop;
            bit_cnt_d  = '0;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            state_d    = ST_START;
        end

        pop = load;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_Tx_Data;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            clks_q     <= CNT_ONE;
            idx_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_idx_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            clks_q     <= clks_d;
            idx_q      <= idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop_idx_q <= stop_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The line is decoded straight from state so that reset forces it high
    // without waiting for a clock edge.
    always_comb begin
        case (state_q)
            ST_START:  o_Tx_Serial = 1'b0;
            ST_DATA:   o_Tx_Serial = shift_q[0];
            ST_PARITY: o_Tx_Serial = par_bit_q;
            default:   o_Tx_Serial = 1'b1;
        endcase
    end

    assign o_Tx_Ready   = !fifo_full;
    assign o_Fifo_Count = count_q;
    assign o_Overflow   = ovf_q;
    assign o_Tx_Busy    = (state_q != ST_IDLE);
    assign o_Tx_Done    = frame_done;

endmodule
